// File: rtl/simple_processor_pkg.sv
// Shared types and instruction field layout for the simple processor.
// Instruction layout, MSB first: [opcode | rd | rs1 | rs2 | imm].
package simple_processor_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_LDI  = 4'h6,
    OP_ADDI = 4'h7,
    OP_BEQZ = 4'h8,
    OP_JMP  = 4'h9,
    OP_HALT = 4'hF
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALTED
  } state_t;

  localparam int RETIRED_W = 16;
  localparam int OP_W      = 4;

  function automatic int instr_w(input int ra_w, input int data_w);
    return OP_W + 3 * ra_w + data_w;
  endfunction

  function automatic int rs2_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int rs1_lsb(input int ra_w, input int data_w);
    return data_w + ra_w;
  endfunction

  function automatic int rd_lsb(input int ra_w, input int data_w);
    return data_w + 2 * ra_w;
  endfunction

  function automatic int op_lsb(input int ra_w, input int data_w);
    return data_w + 3 * ra_w;
  endfunction

endpackage

// File: rtl/sp_regfile.sv
// Register file: two operand read ports, one debug read port, one write port.
// Reads are combinational, writes land on the next edge; r0 always reads zero.
module sp_regfile
  import simple_processor_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int NREGS  = 8,
  localparam int RA_W   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [RA_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RA_W-1:0]   raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [RA_W-1:0]   raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a  = (raddr_a  == '0) ? '0 : regs[raddr_a];
  assign rdata_b  = (raddr_b  == '0) ? '0 : regs[raddr_b];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/simple_processor_p.sv
// Multi-cycle processor: program loaded via write/program_in, runs on start; 3 cycles per instruction.
// Loads accepted only in IDLE/HALTED; SIMPROC_ILLEGAL_TRAP_EN makes opcodes A-E trap instead of NOP.
module simple_processor_p
  import simple_processor_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int NREGS      = 8,
  parameter  int IMEM_DEPTH = 16,
  localparam int RA_W       = $clog2(NREGS),
  localparam int PC_W       = $clog2(IMEM_DEPTH),
  localparam int INSTR_W    = instr_w(RA_W, DATA_W)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 write,
  input  logic [INSTR_W-1:0]   program_in,
  input  logic [RA_W-1:0]      dbg_addr,
  output logic [DATA_W-1:0]    dbg_data,
  output logic                 busy,
  output logic                 halted,
  output logic [PC_W-1:0]      pc,
  output logic [RETIRED_W-1:0] retired,
  output logic                 err
);

  localparam int OP_LSB  = op_lsb(RA_W, DATA_W);
  localparam int RD_LSB  = rd_lsb(RA_W, DATA_W);
  localparam int RS1_LSB = rs1_lsb(RA_W, DATA_W);
  localparam int RS2_LSB = rs2_lsb(DATA_W);

  logic [INSTR_W-1:0] imem [IMEM_DEPTH];
  state_t             state;
  logic [PC_W-1:0]    wr_ptr;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  opa, opb;
  logic [DATA_W-1:0]  rdata_a, rdata_b;

  op_t               op;
  logic [RA_W-1:0]   rd, rs1, rs2;
  logic [DATA_W-1:0] imm;
  logic [PC_W-1:0]   pc_inc, npc;
  logic [DATA_W-1:0] alu_res;
  logic              wb_en, rf_we, load_en;

  assign op  = op_t'(ir[OP_LSB +: OP_W]);
  assign rd  = ir[RD_LSB  +: RA_W];
  assign rs1 = ir[RS1_LSB +: RA_W];
  assign rs2 = ir[RS2_LSB +: RA_W];
  assign imm = ir[DATA_W-1:0];

  // IMEM has no reset so a program survives a reset and can be rerun.
  assign load_en = reset && write && (state == S_IDLE || state == S_HALTED);

  always_ff @(posedge clk) begin
    if (load_en) imem[wr_ptr] <= program_in;
  end

  always_comb begin
    alu_res = '0;
    wb_en   = 1'b0;
    case (op)
      OP_ADD:  begin alu_res = opa + opb; wb_en = 1'b1; end
      OP_SUB:  begin alu_res = opa - opb; wb_en = 1'b1; end
      OP_AND:  begin alu_res = opa & opb; wb_en = 1'b1; end
      OP_OR:   begin alu_res = opa | opb; wb_en = 1'b1; end
      OP_XOR:  begin alu_res = opa ^ opb; wb_en = 1'b1; end
      OP_LDI:  begin alu_res = imm;       wb_en = 1'b1; end
      OP_ADDI: begin alu_res = opa + imm; wb_en = 1'b1; end
      default: ;
    endcase
  end

  assign pc_inc = pc + PC_W'(1);

  always_comb begin
    npc = pc_inc;
    if (op == OP_JMP || (op == OP_BEQZ && opa == '0)) npc = imm[PC_W-1:0];
  end

  assign rf_we = reset && (state == S_EXEC) && wb_en;

  sp_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (rf_we),
    .waddr    (rd),
    .wdata    (alu_res),
    .raddr_a  (rs1),
    .rdata_a  (rdata_a),
    .raddr_b  (rs2),
    .rdata_b  (rdata_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

`ifdef SIMPROC_ILLEGAL_TRAP_EN
  logic err_q;
  logic illegal;
  assign illegal = (ir[OP_LSB +: OP_W] >= 4'hA) && (ir[OP_LSB +: OP_W] <= 4'hE);
  assign err     = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      pc      <= '0;
      wr_ptr  <= '0;
      ir      <= '0;
      opa     <= '0;
      opb     <= '0;
      retired <= '0;
      busy    <= 1'b0;
      halted  <= 1'b0;
`ifdef SIMPROC_ILLEGAL_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      if (load_en) wr_ptr <= wr_ptr + PC_W'(1);
      case (state)
        S_IDLE: if (start) begin
          // Overrides the load-pointer bump above; a same-edge write still commits.
          state   <= S_FETCH;
          busy    <= 1'b1;
          pc      <= '0;
          retired <= '0;
          wr_ptr  <= '0;
`ifdef SIMPROC_ILLEGAL_TRAP_EN
          err_q   <= 1'b0;
`endif
        end
        S_FETCH: begin
          ir    <= imem[pc];
          state <= S_DECODE;
        end
        S_DECODE: begin
          opa   <= rdata_a;
          opb   <= rdata_b;
          state <= S_EXEC;
        end
        S_EXEC: begin
`ifdef SIMPROC_ILLEGAL_TRAP_EN
          if (illegal) begin
            err_q  <= 1'b1;
            state  <= S_HALTED;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
`else
          begin
`endif
            if (retired != '1) retired <= retired + RETIRED_W'(1);
            if (op == OP_HALT) begin
              state  <= S_HALTED;
              busy   <= 1'b0;
              halted <= 1'b1;
            end else begin
              state <= S_FETCH;
              pc    <= npc;
            end
          end
        end
        S_HALTED: if (!start) begin
          state  <= S_IDLE;
          halted <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simple_processor_p.sv
// Bench for simple_processor_p: ISA-level reference model checked every cycle, plus directed programs.
module tb_simple_processor_p;

  localparam int DATA_W = 8, NREGS = 8, IMEM_DEPTH = 16;
  localparam int RA_W = 3, PC_W = 4, INSTR_W = 21;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic               write = 1'b0;
  logic [INSTR_W-1:0] program_in = '0;
  logic [RA_W-1:0]    dbg_addr = '0;
  logic [DATA_W-1:0]  dbg_data;
  logic               busy, halted, err;
  logic [PC_W-1:0]    pc;
  logic [15:0]        retired;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  simple_processor_p #(.DATA_W(DATA_W), .NREGS(NREGS), .IMEM_DEPTH(IMEM_DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .write      (write),
    .program_in (program_in),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .busy       (busy),
    .halted     (halted),
    .pc         (pc),
    .retired    (retired),
    .err        (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 running, 2 halted; an instruction's effect lands on its 3rd cycle.
  int                 m_mode = 0, m_phase = 0, m_pc = 0, m_ret = 0, m_wp = 0;
  bit                 m_err = 1'b0;
  int                 m_regs [NREGS];
  logic [INSTR_W-1:0] m_imem [IMEM_DEPTH];

  task automatic m_exec();
    logic [INSTR_W-1:0] ins = m_imem[m_pc];
    int op  = int'(ins[20:17]);
    int rd  = int'(ins[16:14]);
    int a   = m_regs[int'(ins[13:11])];
    int b   = m_regs[int'(ins[10:8])];
    int imm = int'(ins[7:0]);
    int res = 0;
    bit wb  = 1'b0;
    int npc = (m_pc + 1) % IMEM_DEPTH;
`ifdef SIMPROC_ILLEGAL_TRAP_EN
    if (op >= 10 && op <= 14) begin
      m_err  = 1'b1;
      m_mode = 2;
      return;
    end
`endif
    case (op)
      1: begin res = a + b; wb = 1'b1; end
      2: begin res = a - b; wb = 1'b1; end
      3: begin res = a & b; wb = 1'b1; end
      4: begin res = a | b; wb = 1'b1; end
      5: begin res = a ^ b; wb = 1'b1; end
      6: begin res = imm;   wb = 1'b1; end
      7: begin res = a + imm; wb = 1'b1; end
      8: if (a == 0) npc = imm % IMEM_DEPTH;
      9: npc = imm % IMEM_DEPTH;
      default: ;
    endcase
    if (wb && rd != 0) m_regs[rd] = res & 255;
    if (m_ret < 65535) m_ret++;
    if (op == 15) m_mode = 2;
    else m_pc = npc;
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      m_mode = 0; m_phase = 0; m_pc = 0; m_wp = 0; m_ret = 0; m_err = 1'b0;
      for (int i = 0; i < NREGS; i++) m_regs[i] = 0;
    end else if (m_mode == 1) begin
      if (m_phase < 2) m_phase++;
      else begin
        m_phase = 0;
        m_exec();
      end
    end else begin
      if (write) begin
        m_imem[m_wp] = program_in;
        m_wp = (m_wp + 1) % IMEM_DEPTH;
      end
      if (m_mode == 0 && start) begin
        m_mode = 1; m_phase = 0; m_pc = 0; m_ret = 0; m_err = 1'b0; m_wp = 0;
      end else if (m_mode == 2 && !start) begin
        m_mode = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", busy, m_mode == 1);
      chk("halted", halted, m_mode == 2);
      chk("pc", pc, m_pc);
      chk("retired", retired, m_ret);
      chk("err", err, m_err);
      chk("dbg_data", dbg_data, m_regs[dbg_addr]);
    end
  end

  function automatic logic [INSTR_W-1:0] enc(input int op, input int rd, input int rs1,
                                              input int rs2, input int imm);
    return {op[3:0], rd[2:0], rs1[2:0], rs2[2:0], imm[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [INSTR_W-1:0] ins);
    write = 1'b1;
    program_in = ins;
    tick();
    write = 1'b0;
  endtask

  task automatic chk_reg(input string name, input int r, input int exp);
    dbg_addr = r[RA_W-1:0];
    #1;
    chk(name, dbg_data, exp);
  endtask

  // junk=1 drives write with a stray instruction while the core is busy.
  task automatic run(input bit junk, output int cyc);
    start = 1'b1;
    tick();
    cyc = 0;
    if (junk) begin
      write = 1'b1;
      program_in = enc(6, 1, 0, 0, 8'h55);
    end
    while (!halted && cyc < 400) begin
      tick();
      cyc++;
    end
    write = 1'b0;
    if (!halted) chk("halt_timeout", halted, 1);
  endtask

  task automatic stop();
    start = 1'b0;
    tick();
  endtask

  initial begin
    int cyc;
    reset = 1'b0;
    tick();
    tick();
    cmp_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc, 0);
    chk("rst_retired", retired, 0);
    for (int r = 0; r < NREGS; r++) chk_reg("rst_reg", r, 0);
    reset = 1'b1;
    tick();

    // Fill all of IMEM with NOPs; the load pointer wraps back to 0.
    for (int i = 0; i < IMEM_DEPTH; i++) load(enc(0, 0, 0, 0, 0));

    load(enc(6, 1, 0, 0, 5));
    load(enc(6, 2, 0, 0, 3));
    load(enc(1, 3, 1, 2, 0));
    load(enc(15, 0, 0, 0, 0));
    run(1'b0, cyc);
    chk("basic_latency", cyc, 12);
    chk_reg("basic_r3", 3, 8);
    chk("basic_retired", retired, 4);
    chk("basic_pc", pc, 3);
    tick();
    tick();
    chk("stay_halted", halted, 1);
    stop();
    chk("back_idle_halted", halted, 0);
    chk("back_idle_busy", busy, 0);

    load(enc(6, 1, 0, 0, 8'hFF));
    load(enc(7, 1, 1, 0, 2));
    load(enc(8, 0, 0, 0, 4));
    load(enc(0, 0, 0, 0, 0));
    load(enc(15, 0, 0, 0, 0));
    run(1'b1, cyc);
    chk_reg("wrap_r1", 1, 8'h01);
    chk("wrap_retired", retired, 4);
    chk("wrap_pc", pc, 4);
    stop();
    run(1'b0, cyc);
    chk_reg("rerun_r1", 1, 8'h01);
    chk("rerun_retired", retired, 4);
    stop();

    load(enc(6, 2, 0, 0, 1));
    load(enc(2, 1, 0, 2, 0));
    load(enc(6, 0, 0, 0, 7));
    load(enc(15, 0, 0, 0, 0));
    run(1'b0, cyc);
    chk_reg("sub_r1", 1, 8'hFF);
    chk_reg("ldi_r0", 0, 0);
    chk("ovf_pc", pc, 3);
    stop();

    // Reset while the first instruction is in DECODE.
    start = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    start = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_pc", pc, 0);
    chk_reg("midrst_r1", 1, 0);
    run(1'b0, cyc);
    chk_reg("midrst_rerun_r1", 1, 8'hFF);
    chk("midrst_rerun_retired", retired, 4);
    stop();

    load(enc(6, 1, 0, 0, 9));
    load(enc(6, 3, 0, 0, 4));
    load(enc(11, 3, 1, 1, 0));
    load(enc(6, 2, 0, 0, 6));
    load(enc(15, 0, 0, 0, 0));
    run(1'b0, cyc);
    chk_reg("rsv_r3", 3, 4);
`ifdef SIMPROC_ILLEGAL_TRAP_EN
    chk("trap_err", err, 1);
    chk("trap_pc", pc, 2);
    chk("trap_retired", retired, 2);
`else
    chk("rsv_err", err, 0);
    chk("rsv_pc", pc, 4);
    chk("rsv_retired", retired, 5);
    chk_reg("rsv_r2", 2, 6);
`endif
    stop();

    // Random programs with random start, write, debug address and occasional reset.
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < IMEM_DEPTH; i++)
        load(enc($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 255)));
      start = 1'b1;
      for (int c = 0; c < 150; c++) begin
        tick();
        start      = ($urandom_range(0, 3) != 0);
        write      = ($urandom_range(0, 3) == 0);
        program_in = INSTR_W'($urandom);
        dbg_addr   = RA_W'($urandom_range(0, 7));
        reset      = ($urandom_range(0, 60) != 0);
      end
      write = 1'b0;
      start = 1'b0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
    end

    tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
